// File: rtl/b1_eval_pkg.sv
// Shared types and the b1 evaluation function for the b1_eval_sched scheduler.
package b1_eval_pkg;

  localparam int OP_W  = 3;
  localparam int RES_W = 4;

  typedef enum logic [0:0] {
    ARB   = 1'b0,
    STALL = 1'b1
  } arb_state_e;

  function automatic logic [RES_W-1:0] b1_eval(input logic [OP_W-1:0] op);
    logic [RES_W-1:0] r;
    r[0] = op[2];
    r[1] = op[0] ^ op[1];
    r[2] = (op[0] & op[1] & ~op[2]) | (~op[0] & ~op[1] & op[2]);
    r[3] = ~op[2];
    return r;
  endfunction

endpackage

// File: rtl/b1_eval_sched_arbiter.sv
// Round-robin arbiter: first valid requester at or after ptr wins; no grant while stalled.
module b1_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [IDW-1:0]  ptr,
  input  logic            stall,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx,
  output logic            any_grant
);

  logic           found_s;
  logic [IDW-1:0] idx_s;
  int             off_s;
  int             best_s;

  // Pick the valid requester with the smallest rotational distance from ptr.
  always_comb begin
    found_s = 1'b0;
    idx_s   = '0;
    off_s   = 0;
    best_s  = NREQ;
    for (int i = 0; i < NREQ; i++) begin
      off_s = (i + NREQ - int'(ptr)) % NREQ;
      if (req_valid[i] && (off_s < best_s)) begin
        best_s  = off_s;
        idx_s   = IDW'(i);
        found_s = 1'b1;
      end else begin
        best_s  = best_s;
      end
    end
  end

  // Expand the winner into a one-hot grant, suppressed during a stall.
  always_comb begin
    grant = '0;
    for (int i = 0; i < NREQ; i++) begin
      grant[i] = found_s & ~stall & (idx_s == IDW'(i));
    end
  end

  assign grant_idx = idx_s;
  assign any_grant = found_s & ~stall;

endmodule

// File: rtl/b1_eval_sched.sv
// Round-robin scheduler feeding a shared 2-stage b1 evaluation pipeline.
// Optional response counter output rsp_count enabled by B1_EVAL_STATS_EN.
module b1_eval_sched
  import b1_eval_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [OP_W*NREQ-1:0] req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [RES_W-1:0]     rsp_data,
  output logic                 busy
`ifdef B1_EVAL_STATS_EN
  ,
  output logic [15:0]          rsp_count
`endif
);

  arb_state_e       state_q, state_d;
  logic             arb_en_s;
  logic             stall_s;
  logic [NREQ-1:0]  gnt_s;
  logic [IDW-1:0]   gnt_idx_s;
  logic             gnt_any_s;
  logic [OP_W-1:0]  op_sel_s;

  logic             v1_q, v1_d;
  logic [OP_W-1:0]  op1_q, op1_d;
  logic [IDW-1:0]   id1_q, id1_d;
  logic             v2_q, v2_d;
  logic [RES_W-1:0] res2_q, res2_d;
  logic [IDW-1:0]   id2_q, id2_d;
  logic [IDW-1:0]   ptr_q, ptr_d;

  assign stall_s = v2_q & ~rsp_ready;

  b1_rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req_valid (req_valid),
    .ptr       (ptr_q),
    .stall     (~arb_en_s),
    .grant     (gnt_s),
    .grant_idx (gnt_idx_s),
    .any_grant (gnt_any_s)
  );

  // Arbiter state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB;
    end else begin
      state_q <= state_d;
    end
  end

  // Arbiter next state: park in STALL for exactly as long as the response port is blocked.
  always_comb begin
    case (state_q)
      ARB:     state_d = stall_s ? STALL : ARB;
      STALL:   state_d = stall_s ? STALL : ARB;
      default: state_d = ARB;
    endcase
  end

  // Arbiter outputs; gated by rst_n so no grant is offered while held in reset.
  always_comb begin
    case (state_q)
      ARB:     arb_en_s = rst_n & ~stall_s;
      STALL:   arb_en_s = rst_n & ~stall_s;
      default: arb_en_s = 1'b0;
    endcase
  end

  // One-hot grant makes an AND-OR operand mux sufficient.
  always_comb begin
    op_sel_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      op_sel_s = op_sel_s | (req_data[OP_W*i +: OP_W] & {OP_W{gnt_s[i]}});
    end
  end

  // Pipeline and pointer next state; everything holds while stalled.
  always_comb begin
    v1_d   = v1_q;
    op1_d  = op1_q;
    id1_d  = id1_q;
    v2_d   = v2_q;
    res2_d = res2_q;
    id2_d  = id2_q;
    ptr_d  = ptr_q;
    if (!stall_s) begin
      v1_d = gnt_any_s;
      v2_d = v1_q;
      if (gnt_any_s) begin
        op1_d = op_sel_s;
        id1_d = gnt_idx_s;
        ptr_d = (gnt_idx_s == IDW'(NREQ - 1)) ? '0 : gnt_idx_s + IDW'(1);
      end else begin
        ptr_d = ptr_q;
      end
      if (v1_q) begin
        res2_d = b1_eval(op1_q);
        id2_d  = id1_q;
      end else begin
        res2_d = res2_q;
      end
    end else begin
      v1_d = v1_q;
    end
  end

  // Pipeline and pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q   <= 1'b0;
      op1_q  <= '0;
      id1_q  <= '0;
      v2_q   <= 1'b0;
      res2_q <= '0;
      id2_q  <= '0;
      ptr_q  <= '0;
    end else begin
      v1_q   <= v1_d;
      op1_q  <= op1_d;
      id1_q  <= id1_d;
      v2_q   <= v2_d;
      res2_q <= res2_d;
      id2_q  <= id2_d;
      ptr_q  <= ptr_d;
    end
  end

  assign req_ready = gnt_s;
  assign rsp_valid = v2_q;
  assign rsp_id    = id2_q;
  assign rsp_data  = res2_q;
  assign busy      = v1_q | v2_q;

`ifdef B1_EVAL_STATS_EN
  logic [15:0] cnt_q, cnt_d;

  // Accepted-response counter, sticks at all-ones.
  always_comb begin
    if (v2_q && rsp_ready && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign rsp_count = cnt_q;
`endif

endmodule

// File: tb/tb_b1_eval_sched.sv
// Scoreboard bench for b1_eval_sched: grants modelled round-robin, results queued and popped on response.
module tb_b1_eval_sched;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  typedef struct {
    int         id;
    logic [3:0] data;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [3*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [3:0]        rsp_data;
  logic              busy;
`ifdef B1_EVAL_STATS_EN
  logic [15:0]       rsp_count;
`endif

  logic       valid_a [NREQ];
  logic [2:0] op_a    [NREQ];
  exp_t       exp_q[$];
  int         mptr;
  int         grant_cnt [NREQ];
  int         acc_cnt;
  int         n_tests = 0;
  int         n_fail  = 0;

  b1_eval_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .busy      (busy)
`ifdef B1_EVAL_STATS_EN
    ,
    .rsp_count (rsp_count)
`endif
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int k = 0; k < NREQ; k++) begin
      req_valid[k]       = valid_a[k];
      req_data[3*k +: 3] = op_a[k];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] model(input logic [2:0] p);
    logic [3:0] r;
    r[0] = p[2];
    r[1] = (p[0] != p[1]);
    r[2] = (p == 3'b011) || (p == 3'b100);
    r[3] = !p[2];
    return r;
  endfunction

  function automatic int rr_pick(input int p);
    int idx;
    for (int k = 0; k < NREQ; k++) begin
      idx = (p + k) % NREQ;
      if (valid_a[idx]) return idx;
    end
    return -1;
  endfunction

  // Monitor: predicts grants, fills the scoreboard and checks responses.
  always @(negedge clk) begin : mon
    logic [NREQ-1:0] exp_ready;
    int w;
    exp_t e;
    exp_ready = '0;
    w = -1;
    if (!rst_n) begin
      exp_q.delete();
      mptr    = 0;
      acc_cnt = 0;
      check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_req_ready", 32'(req_ready), 32'd0);
    end else begin
      if (!(rsp_valid && !rsp_ready)) begin
        w = rr_pick(mptr);
        if (w >= 0) exp_ready[w] = 1'b1;
      end
      check_eq("req_ready", 32'(req_ready), 32'(exp_ready));
      if (w >= 0) begin
        e.id   = w;
        e.data = model(op_a[w]);
        exp_q.push_back(e);
        grant_cnt[w]++;
        mptr = (w + 1) % NREQ;
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("rsp_unexpected", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          check_eq("rsp_id", 32'(rsp_id), 32'(e.id));
          check_eq("rsp_data", 32'(rsp_data), 32'(e.data));
          acc_cnt++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit got;
    rst_n     = 1'b0;
    rsp_ready = 1'b1;
    for (int k = 0; k < NREQ; k++) begin
      valid_a[k]   = 1'b0;
      op_a[k]      = 3'd0;
      grant_cnt[k] = 0;
    end
    repeat (3) tick();
    check_eq("rst_rsp_id", 32'(rsp_id), 32'd0);
    check_eq("rst_rsp_data", 32'(rsp_data), 32'd0);
    rst_n = 1'b1;
    tick();

    // Single request from requester 2, op 3'b011.
    valid_a[2] = 1'b1;
    op_a[2]    = 3'b011;
    @(negedge clk);
    check_eq("single_ready", 32'(req_ready), 32'h4);
    tick();
    valid_a[2] = 1'b0;
    @(negedge clk);
    check_eq("single_lat1", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    check_eq("single_valid", 32'(rsp_valid), 32'd1);
    check_eq("single_id", 32'(rsp_id), 32'd2);
    check_eq("single_data", 32'(rsp_data), 32'hC);
    repeat (3) tick();

    // Function sweep: requester 0 streams ops 0..7 back to back.
    valid_a[0] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      op_a[0] = 3'(k);
      @(negedge clk);
      check_eq("sweep_ready", 32'(req_ready), 32'h1);
      if (k >= 2) check_eq("sweep_stream", 32'(rsp_valid), 32'd1);
      tick();
    end
    valid_a[0] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check_eq("sweep_tail", 32'(rsp_valid), 32'd1);
      tick();
    end
    @(negedge clk);
    check_eq("sweep_idle", 32'(busy), 32'd0);
    tick();

    // Fairness: all requesters valid for 40 grants.
    for (int k = 0; k < NREQ; k++) begin
      grant_cnt[k] = 0;
      op_a[k]      = 3'(2 * k + 1);
      valid_a[k]   = 1'b1;
    end
    repeat (40) tick();
    for (int k = 0; k < NREQ; k++) valid_a[k] = 1'b0;
    for (int k = 0; k < NREQ; k++) check_eq("fair_share", 32'(grant_cnt[k]), 32'd10);
    repeat (3) tick();

    // Backpressure with two operands in flight and a third requester waiting.
    rsp_ready  = 1'b0;
    valid_a[1] = 1'b1;
    op_a[1]    = 3'd5;
    tick();
    valid_a[1] = 1'b0;
    valid_a[3] = 1'b1;
    op_a[3]    = 3'd6;
    tick();
    valid_a[3] = 1'b0;
    valid_a[2] = 1'b1;
    op_a[2]    = 3'd7;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_eq("bp_ready", 32'(req_ready), 32'd0);
      check_eq("bp_valid", 32'(rsp_valid), 32'd1);
      check_eq("bp_id", 32'(rsp_id), 32'd1);
      check_eq("bp_data", 32'(rsp_data), 32'h3);
      check_eq("bp_busy", 32'(busy), 32'd1);
      tick();
    end
    rsp_ready = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      got = req_ready[2];
      tick();
    end
    check_eq("bp_grant_timeout", 32'(got), 32'd1);
    valid_a[2] = 1'b0;
    repeat (4) tick();

    // Reset with both stages occupied and requesters still asking.
    valid_a[1] = 1'b1;
    valid_a[2] = 1'b1;
    op_a[1]    = 3'd2;
    op_a[2]    = 3'd4;
    tick();
    tick();
    check_eq("pre_rst_busy", 32'(busy), 32'd1);
    for (int k = 0; k < NREQ; k++) valid_a[k] = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_valid", 32'(rsp_valid), 32'd0);
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    check_eq("mid_rst_ready", 32'(req_ready), 32'd0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_first_grant", 32'(req_ready), 32'h1);
    tick();
    for (int k = 0; k < NREQ; k++) valid_a[k] = 1'b0;
    repeat (4) tick();

    check_eq("sb_empty", 32'(exp_q.size()), 32'd0);
`ifdef B1_EVAL_STATS_EN
    check_eq("rsp_count", 32'(rsp_count), 32'(acc_cnt));
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
